// File: rtl/hdd_sector_host.sv
// hdd_sector_host: moves one 512-byte sector between the HDD controller's sector RAM and a block backend
module hdd_sector_host #(
  parameter logic [31:0] LBA_BASE = 32'd0,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] hdd_sector,
  input  logic        hdd_protect,
  output logic [8:0]  ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  input  logic [7:0]  ram_do,
  output logic [31:0] blk_lba,
  output logic        blk_rd,
  output logic        blk_wr,
  input  logic        blk_ack,
  input  logic [7:0]  blk_rd_data,
  input  logic        blk_rd_valid,
  output logic [7:0]  blk_wr_data,
  output logic        blk_wr_valid,
  input  logic        blk_wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_FETCH, WR_DATA, DONE, ERR} state_t;
  state_t state, state_nx;
  logic read_q, write_q, pend_rd, pend_wr;
  logic [9:0] cnt;
  logic [23:0] timer;
  logic last, timed_out, refused;
  assign last = cnt == 10'd511;
  assign timed_out = timer == TIMEOUT - 24'd1;
  // the protect check happens only on the first WR_REQ cycle, before blk_wr is ever shown
  assign refused = state == WR_REQ && timer == '0 && hdd_protect;
  always_ff @(posedge clk_sys) state <= !reset_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = pend_wr ? WR_REQ : pend_rd ? RD_REQ : IDLE;
      RD_REQ:   state_nx = blk_ack ? RD_DATA : timed_out ? ERR : RD_REQ;
      RD_DATA:  state_nx = blk_rd_valid && last ? DONE : RD_DATA;
      WR_REQ:   state_nx = refused ? ERR : blk_ack ? WR_FETCH : timed_out ? ERR : WR_REQ;
      WR_FETCH: state_nx = WR_DATA;
      WR_DATA:  state_nx = !blk_wr_ready ? WR_DATA : last ? DONE : WR_FETCH;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    blk_rd = state == RD_REQ || state == RD_DATA;
    blk_wr = (state == WR_REQ && !refused) || state == WR_FETCH || state == WR_DATA;
    blk_wr_valid = state == WR_DATA;
    done = state == DONE;
    err = state == ERR;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      read_q <= hdd_read;
      write_q <= hdd_write;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
      cnt <= '0;
      timer <= '0;
      blk_lba <= '0;
      ram_addr <= '0;
      ram_di <= '0;
      ram_we <= 1'b0;
      blk_wr_data <= '0;
    end else begin
      read_q <= hdd_read;
      write_q <= hdd_write;
      pend_rd <= (hdd_read && !read_q) || (pend_rd && !(state == IDLE && !pend_wr));
      pend_wr <= (hdd_write && !write_q) || (pend_wr && state != IDLE);
      timer <= (state == RD_REQ || state == WR_REQ) ? timer + 24'd1 : '0;
      ram_we <= state == RD_DATA && blk_rd_valid;
      if (state == IDLE && (pend_rd || pend_wr))
        blk_lba <= LBA_BASE + {16'd0, hdd_sector};
      if (state == IDLE)
        cnt <= '0;
      else if ((state == RD_DATA && blk_rd_valid) || (state == WR_DATA && blk_wr_ready))
        cnt <= cnt + 10'd1;
      if (state == RD_DATA && blk_rd_valid) begin
        ram_addr <= cnt[8:0];
        ram_di <= blk_rd_data;
      end
      // addresses are issued one cycle ahead so a registered-output RAM keeps up with WR_FETCH
      if (state == IDLE && pend_wr)
        ram_addr <= '0;
      if (state == WR_FETCH) begin
        blk_wr_data <= ram_do;
        if (!last)
          ram_addr <= cnt[8:0] + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_hdd_sector_host.sv
// tb_hdd_sector_host: scoreboard bench; stimulus queues expected RAM writes, backend bytes and events
module tb_hdd_sector_host;
  logic clk = 1'b0;
  logic reset_n, hdd_read, hdd_write, hdd_protect;
  logic [15:0] hdd_sector;
  logic [8:0] ram_addr;
  logic [7:0] ram_di, ram_do, blk_rd_data, blk_wr_data;
  logic ram_we, blk_rd, blk_wr, blk_ack, blk_rd_valid, blk_wr_valid, blk_wr_ready, busy, done, err;
  logic [31:0] blk_lba;
  logic [7:0] mem [512];
  logic ram_load = 1'b0;
  logic ack_en = 1'b1, junk = 1'b0;
  int stop_at = 512, bk_state = 0, bk_cnt = 0;
  int checks = 0, failures = 0;
  logic [16:0] ram_q [$];
  logic [7:0] wr_q [$];
  logic [33:0] evt_q [$];
  localparam logic [1:0] EV_RD = 2'd0, EV_WR = 2'd1, EV_DONE = 2'd2, EV_ERR = 2'd3;

  hdd_sector_host #(.LBA_BASE(32'h100), .TIMEOUT(24'd16)) dut (
    .clk_sys(clk), .reset_n(reset_n), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .hdd_sector(hdd_sector), .hdd_protect(hdd_protect), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_we(ram_we), .ram_do(ram_do), .blk_lba(blk_lba), .blk_rd(blk_rd), .blk_wr(blk_wr),
    .blk_ack(blk_ack), .blk_rd_data(blk_rd_data), .blk_rd_valid(blk_rd_valid),
    .blk_wr_data(blk_wr_data), .blk_wr_valid(blk_wr_valid), .blk_wr_ready(blk_wr_ready),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  // sector RAM with registered read data
  always @(posedge clk) begin
    if (ram_load) for (int i = 0; i < 512; i++) mem[i] <= i[7:0];
    else if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected output %h with nothing expected", name, act);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [33:0] ev(input logic [1:0] k, input logic [31:0] lba);
    return {k, lba};
  endfunction

  task automatic expect_read(input logic [31:0] lba, input int n, input bit full);
    evt_q.push_back(ev(EV_RD, lba));
    for (int i = 0; i < n; i++) ram_q.push_back({i[8:0], i[7:0] ^ 8'hA5});
    if (full) evt_q.push_back(ev(EV_DONE, lba));
  endtask

  task automatic expect_write(input logic [31:0] lba);
    evt_q.push_back(ev(EV_WR, lba));
    for (int i = 0; i < 512; i++) wr_q.push_back(i[7:0]);
    evt_q.push_back(ev(EV_DONE, lba));
  endtask

  task automatic pulse_read;
    hdd_read = 1'b1;
    tick;
    hdd_read = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int b = 0;
    tick;
    while ((busy || evt_q.size() != 0) && b < 20000) begin
      tick;
      b++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_events_left"}, 64'(evt_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({busy, blk_rd, blk_wr, ram_we, done, err, blk_wr_valid, ram_addr, ram_di, blk_wr_data}), 64'd0);
    check({name, "_lba"}, 64'(blk_lba), 64'd0);
  endtask

  // backend: acks immediately, streams read bytes i^A5 with gaps, random write backpressure
  initial begin : backend
    blk_ack = 1'b0; blk_rd_valid = 1'b0; blk_rd_data = '0; blk_wr_ready = 1'b0;
    forever begin
      tick;
      blk_ack = 1'b0;
      blk_rd_valid = 1'b0;
      blk_wr_ready = $urandom_range(0, 1) == 1;
      if (junk) begin
        blk_ack = 1'b1;
        blk_rd_valid = 1'b1;
        blk_rd_data = 8'h3C;
      end else if (bk_state == 0) begin
        if (ack_en && (blk_rd || blk_wr)) begin
          blk_ack = 1'b1;
          bk_state = blk_rd ? 1 : 2;
          bk_cnt = 0;
        end
      end else if (bk_state == 1) begin
        if (!blk_rd) bk_state = 0;
        else if (bk_cnt < stop_at && $urandom_range(0, 3) != 0) begin
          blk_rd_valid = 1'b1;
          blk_rd_data = bk_cnt[7:0] ^ 8'hA5;
          bk_cnt++;
        end
      end else if (!blk_wr) bk_state = 0;
    end
  end

  task automatic see_event(input logic [1:0] k);
    if (evt_q.size() == 0) unexpected("event", 64'({k, blk_lba}));
    else check("event", 64'({k, blk_lba}), 64'(evt_q.pop_front()));
  endtask

  initial begin : monitor
    logic prd, pwr;
    prd = 1'b0;
    pwr = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        if (ram_q.size() == 0) unexpected("ram_we", 64'({ram_addr, ram_di}));
        else check("ram_write", 64'({ram_addr, ram_di}), 64'(ram_q.pop_front()));
      end
      if (blk_wr_valid && blk_wr_ready) begin
        if (wr_q.size() == 0) unexpected("blk_wr_byte", 64'(blk_wr_data));
        else check("blk_wr_byte", 64'(blk_wr_data), 64'(wr_q.pop_front()));
      end
      if (blk_rd && !prd) see_event(EV_RD);
      if (blk_wr && !pwr) see_event(EV_WR);
      if (done) see_event(EV_DONE);
      if (err) see_event(EV_ERR);
      prd = blk_rd;
      pwr = blk_wr;
    end
  end

  initial begin : stimulus
    int k, bad;
    reset_n = 1'b0; hdd_read = 1'b0; hdd_write = 1'b0; hdd_protect = 1'b0; hdd_sector = '0;
    repeat (3) tick;
    check_zero("reset_outputs");
    reset_n = 1'b1;
    tick;
    // read of sector 5
    hdd_sector = 16'h0005;
    expect_read(32'h105, 512, 1'b1);
    pulse_read;
    wait_quiet("read");
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== (i[7:0] ^ 8'hA5)) bad++;
    check("read_ram_image", 64'(bad), 64'd0);
    // write of sector FFFF from a preloaded RAM
    ram_load = 1'b1;
    tick;
    ram_load = 1'b0;
    hdd_sector = 16'hFFFF;
    expect_write(32'h100FF);
    hdd_write = 1'b1;
    tick;
    hdd_write = 1'b0;
    wait_quiet("write");
    // protected write is refused without backend activity
    hdd_protect = 1'b1;
    hdd_sector = 16'h0002;
    evt_q.push_back(ev(EV_ERR, 32'h102));
    hdd_write = 1'b1;
    k = 0;
    do begin
      tick;
      k++;
      if (k == 1) hdd_write = 1'b0;
    end while (!err && k < 20);
    check("protect_err_latency", 64'(k), 64'd3);
    wait_quiet("protect");
    hdd_protect = 1'b0;
    // timeout with no ack
    ack_en = 1'b0;
    hdd_sector = 16'h0007;
    evt_q.push_back(ev(EV_RD, 32'h107));
    evt_q.push_back(ev(EV_ERR, 32'h107));
    pulse_read;
    k = 0;
    while (!blk_rd && k < 20) begin tick; k++; end
    k = 0;
    while (!err && k < 40) begin tick; k++; end
    check("timeout_cycles", 64'(k), 64'd16);
    check("timeout_blk_rd_low", 64'(blk_rd), 64'd0);
    tick;
    check("timeout_back_idle", 64'(busy), 64'd0);
    ack_en = 1'b1;
    wait_quiet("timeout");
    // simultaneous edges then a merged pair of extra read edges
    hdd_sector = 16'h0010;
    expect_write(32'h110);
    expect_read(32'h110, 512, 1'b1);
    expect_read(32'h110, 512, 1'b1);
    hdd_read = 1'b1;
    hdd_write = 1'b1;
    tick;
    hdd_read = 1'b0;
    hdd_write = 1'b0;
    k = 0;
    while (bk_state != 1 && k < 5000) begin tick; k++; end
    check("queued_read_started", 64'(bk_state), 64'd1);
    pulse_read;
    tick;
    pulse_read;
    wait_quiet("queued");
    // reset in the middle of a read
    hdd_sector = 16'h0020;
    stop_at = 201;
    expect_read(32'h120, 201, 1'b0);
    pulse_read;
    k = 0;
    while (bk_cnt != 201 && k < 2000) begin tick; k++; end
    check("midread_bytes_sent", 64'(bk_cnt), 64'd201);
    repeat (3) tick;
    reset_n = 1'b0;
    tick;
    check_zero("midread_reset_outputs");
    reset_n = 1'b1;
    junk = 1'b1;
    repeat (4) tick;
    junk = 1'b0;
    stop_at = 512;
    tick;
    check("after_junk_idle", 64'(busy), 64'd0);
    expect_read(32'h120, 512, 1'b1);
    pulse_read;
    wait_quiet("fresh_read");
    repeat (4) tick;
    check("ram_q_drained", 64'(ram_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("evt_q_drained", 64'(evt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
